offset_null_calibrator: RTL and testbench

Calibration controller for the other end of the differential amplifier's null interface. It drives the null pins and the test inputs, and reads back the amplifier's registered difference output. On request it shorts the amp inputs to zero and releases both null pins. It then averages the raw output offset over 2^AVG_LOG2 samples and latches a null decision plus a signed offset estimate for the downstream gain stage.

---
 rtl/offset_null_calibrator_pkg.sv | 17 +
 rtl/offset_null_calibrator_accumulator.sv | 42 ++++
 rtl/offset_null_calibrator.sv | 171 +++++++++++++++++
 tb/tb_offset_null_calibrator.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/offset_null_calibrator_pkg.sv
// Shared types and constants for the offset-null calibration controller.
package offset_null_calibrator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } cal_state_e;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_AVG_LOG2   = 3;
    // Raw output offset of the amplifier model driven by the bench.
    localparam int AMP_RAW_OFFSET = 5;

endpackage

// File: rtl/offset_null_calibrator_accumulator.sv
// Signed sample accumulator with clear/enable; sized so 2^AVG_LOG2 samples never overflow.
module offset_accumulator
    import offset_null_calibrator_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear_i,
    input  logic                              enable_i,
    input  logic signed [WIDTH-1:0]           sample_i,
    output logic signed [WIDTH+AVG_LOG2-1:0]  sum_o,
    output logic        [AVG_LOG2:0]          count_o
);

    localparam int AW = WIDTH + AVG_LOG2;

    logic signed [AW-1:0]     sum_q;
    logic        [AVG_LOG2:0] count_q;

    // Running sum and sample count; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= {AW{1'b0}};
            count_q <= {(AVG_LOG2+1){1'b0}};
        end else if (clear_i) begin
            sum_q   <= {AW{1'b0}};
            count_q <= {(AVG_LOG2+1){1'b0}};
        end else if (enable_i) begin
            sum_q   <= sum_q + {{AVG_LOG2{sample_i[WIDTH-1]}}, sample_i};
            count_q <= count_q + {{AVG_LOG2{1'b0}}, 1'b1};
        end else begin
            sum_q   <= sum_q;
            count_q <= count_q;
        end
    end

    assign sum_o   = sum_q;
    assign count_o = count_q;

endmodule

// File: rtl/offset_null_calibrator.sv
// Calibration FSM: shorts the amp inputs, averages its output offset and latches the null decision.
module offset_null_calibrator
    import offset_null_calibrator_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int AVG_LOG2      = DEF_AVG_LOG2,
    parameter int SETTLE_CYCLES = 2,
    parameter int THRESHOLD     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] amp_out,
    output logic                    cal_mode,
    output logic signed [WIDTH-1:0] cal_v_plus,
    output logic signed [WIDTH-1:0] cal_v_minus,
    output logic                    offset_null1,
    output logic                    offset_null2,
    output logic signed [WIDTH-1:0] offset_est,
    output logic                    busy,
    output logic                    done,
    output logic                    cal_valid
);

    localparam int AW = WIDTH + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]  LAST_SAMPLE = CW'((2 ** AVG_LOG2) - 1);
    localparam logic [WIDTH:0] THR_EXT     = (WIDTH+1)'(THRESHOLD);

    // Magnitude in one extra bit so the most negative value stays exact.
    function automatic logic [WIDTH:0] abs_ext(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH:0] e;
        e = {v[WIDTH-1], v};
        if (e[WIDTH]) begin
            abs_ext = -e;
        end else begin
            abs_ext = e;
        end
    endfunction

    cal_state_e              state_q, state_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic                    cal_mode_q, cal_mode_d;
    logic                    null1_q, null1_d;
    logic                    null2_q, null2_d;
    logic signed [WIDTH-1:0] est_q, est_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;

    logic                    acc_clear_s;
    logic                    acc_en_s;
    logic signed [AW-1:0]    sum_s;
    logic [CW-1:0]           count_s;
    logic signed [WIDTH-1:0] mean_s;
    logic                    unused_low_s;

    offset_accumulator #(
        .WIDTH    (WIDTH),
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (acc_clear_s),
        .enable_i (acc_en_s),
        .sample_i (amp_out),
        .sum_o    (sum_s),
        .count_o  (count_s)
    );

    // Dropping the low AVG_LOG2 bits is an arithmetic shift, i.e. floor division.
    assign mean_s       = sum_s[AW-1:AVG_LOG2];
    assign unused_low_s = ^sum_s[AVG_LOG2-1:0];

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        cal_mode_d  = cal_mode_q;
        null1_d     = null1_q;
        null2_d     = null2_q;
        est_d       = est_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        acc_clear_s = 1'b0;
        acc_en_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SETTLE;
                    settle_d    = {SW{1'b0}};
                    cal_mode_d  = 1'b1;
                    null1_d     = 1'b0;
                    null2_d     = 1'b0;
                    acc_clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_ACCUM;
                end else begin
                    settle_d = settle_q + {{(SW-1){1'b0}}, 1'b1};
                end
            end
            ST_ACCUM: begin
                acc_en_s = 1'b1;
                if (count_s == LAST_SAMPLE) begin
                    state_d = ST_DECIDE;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DECIDE: begin
                est_d      = mean_s;
                null1_d    = (abs_ext(mean_s) >= THR_EXT);
                null2_d    = 1'b0;
                done_d     = 1'b1;
                cal_mode_d = 1'b0;
                valid_d    = 1'b1;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            settle_q   <= {SW{1'b0}};
            cal_mode_q <= 1'b0;
            null1_q    <= 1'b0;
            null2_q    <= 1'b0;
            est_q      <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            cal_mode_q <= cal_mode_d;
            null1_q    <= null1_d;
            null2_q    <= null2_d;
            est_q      <= est_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
        end
    end

    assign cal_mode     = cal_mode_q;
    assign cal_v_plus   = {WIDTH{1'b0}};
    assign cal_v_minus  = {WIDTH{1'b0}};
    assign offset_null1 = null1_q;
    assign offset_null2 = null2_q;
    assign offset_est   = est_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cal_valid    = valid_q;

endmodule

// File: tb/tb_offset_null_calibrator.sv
// Directed bench for offset_null_calibrator with hand-computed expected estimates and timing.
module tb_offset_null_calibrator;
    import offset_null_calibrator_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [15:0] amp_out;
    logic               cal_mode;
    logic signed [15:0] cal_v_plus;
    logic signed [15:0] cal_v_minus;
    logic               offset_null1;
    logic               offset_null2;
    logic signed [15:0] offset_est;
    logic               busy;
    logic               done;
    logic               cal_valid;

    int n_checks = 0;
    int n_errors = 0;
    logic signed [15:0] samples [8];

    offset_null_calibrator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .amp_out      (amp_out),
        .cal_mode     (cal_mode),
        .cal_v_plus   (cal_v_plus),
        .cal_v_minus  (cal_v_minus),
        .offset_null1 (offset_null1),
        .offset_null2 (offset_null2),
        .offset_est   (offset_est),
        .busy         (busy),
        .done         (done),
        .cal_valid    (cal_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_mode"},  int'(cal_mode), 0);
        chk({tag, "_null1"}, int'(offset_null1), 0);
        chk({tag, "_null2"}, int'(offset_null2), 0);
        chk({tag, "_est"},   int'(offset_est), 0);
        chk({tag, "_done"},  int'(done), 0);
        chk({tag, "_valid"}, int'(cal_valid), 0);
        chk({tag, "_vplus"}, int'(cal_v_plus), 0);
        chk({tag, "_vminus"}, int'(cal_v_minus), 0);
    endtask

    // Start pulse at edge k; samples[i] is presented for edge k+3+i, junk elsewhere.
    // hold_from > 0 raises start again from loop step hold_from and keeps it high.
    task automatic run_cal(input string tag, input int exp_est, input int exp_n1, input int hold_from);
        int done_cnt;
        int done_at;
        done_cnt = 0;
        done_at  = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (hold_from > 0 && j >= hold_from) start = 1'b1;
            else start = 1'b0;
            if (j >= 3 && j <= 10) amp_out = samples[j-3];
            else amp_out = 16'sd999;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (j == 1) begin
                chk({tag, "_busy_on"}, int'(busy), 1);
                chk({tag, "_mode_on"}, int'(cal_mode), 1);
                chk({tag, "_null1_clr"}, int'(offset_null1), 0);
            end
            if (j == 12) begin
                chk({tag, "_est"},   int'(offset_est), exp_est);
                chk({tag, "_null1"}, int'(offset_null1), exp_n1);
                chk({tag, "_null2"}, int'(offset_null2), 0);
                chk({tag, "_valid"}, int'(cal_valid), 1);
                chk({tag, "_mode_off"}, int'(cal_mode), 0);
            end
            if (j == 13) chk({tag, "_idle_busy"}, int'(busy), 0);
            if (j == 14) begin
                chk({tag, "_retrig_busy"}, int'(busy), (hold_from > 0) ? 1 : 0);
                chk({tag, "_retrig_mode"}, int'(cal_mode), (hold_from > 0) ? 1 : 0);
            end
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_at"},  done_at, 12);
        start = 1'b0;
    endtask

    task automatic fill(input logic signed [15:0] v);
        for (int i = 0; i < 8; i++) samples[i] = v;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        amp_out = 16'sd0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("post_reset");

        fill(-16'(AMP_RAW_OFFSET));
        run_cal("nominal", -5, 1, 0);

        fill(16'sd1);
        run_cal("below_thr", 1, 0, 0);

        fill(16'sd2);
        run_cal("at_thr", 2, 1, 0);

        for (int i = 0; i < 8; i++) samples[i] = (i < 4) ? -16'sd3 : -16'sd2;
        run_cal("floor", -3, 1, 0);

        fill(16'sh8000);
        run_cal("extreme", -32768, 1, 0);

        // Reset in the middle of ACCUM clears everything asynchronously.
        @(negedge clk);
        start = 1'b1;
        amp_out = 16'sd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("after_mid_reset");

        // Start raised at ACCUM sample 4 and held: ignored until IDLE, then re-triggers.
        fill(-16'sd5);
        run_cal("busy_start", -5, 1, 7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
